// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   Sits between fetch and execute. Each cycle it decides whether the
//   fetched instruction pair can issue together. A dependent pair, or a pair
//   containing a branch, is split across two cycles and fetch is held off.
//   A taken branch flushes in-flight work and discards FLUSH_CYCLES valid
//   fetch pairs.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   fetch_instr1/2, fetch_valid older/younger fetched instruction, pair valid
//   exec_ready                  execute stage accepts an issue this cycle
//   branch_taken                taken branch resolved in execute
//   issue1/2_valid, _instr      registered issue slots
//   fetch_stall                 combinational: fetch holds its pair
//   fetch_single                registered single-fetch request
//   busy                        scheduler is not in RUN
//
// Optional build macro DUAL_ISSUE_PERF_EN adds saturating 16-bit counters
//   perf_dual, perf_split and perf_flush as extra output ports.

module dual_issue_scheduler #(
   parameter int unsigned INSTR_W      = 16,
   parameter int unsigned WR_OP_MAX    = 9,
   parameter logic [3:0]  BR_OP_A      = 4'hC,
   parameter logic [3:0]  BR_OP_B      = 4'hD,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] fetch_instr1,
   input  logic [INSTR_W-1:0] fetch_instr2,
   input  logic               fetch_valid,
   input  logic               exec_ready,
   input  logic               branch_taken,
   output logic               issue1_valid,
   output logic [INSTR_W-1:0] issue1_instr,
   output logic               issue2_valid,
   output logic [INSTR_W-1:0] issue2_instr,
   output logic               fetch_stall,
   output logic               fetch_single,
   output logic               busy
`ifdef DUAL_ISSUE_PERF_EN
   ,
   output logic [15:0]        perf_dual,
   output logic [15:0]        perf_split,
   output logic [15:0]        perf_flush
`endif
);

   typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

   localparam logic [3:0] WR_MAX     = 4'(WR_OP_MAX);
   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] hold_q, hold_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               v1_d, v2_d, single_d;
   logic [INSTR_W-1:0] i1_d, i2_d;

   // Instruction field decode
   logic [3:0] op1, op2, rd1, rd2, rs1_2, rs2_2;
   logic       nop1, nop2, wr1, wr2, br1, br2, hazard, split;

   assign op1   = fetch_instr1[15:12];
   assign rd1   = fetch_instr1[11:8];
   assign op2   = fetch_instr2[15:12];
   assign rd2   = fetch_instr2[11:8];
   assign rs1_2 = fetch_instr2[7:4];
   assign rs2_2 = fetch_instr2[3:0];

   assign nop1 = (op1 == 4'd0);
   assign nop2 = (op2 == 4'd0);
   assign wr1  = (op1 >= 4'd1) && (op1 <= WR_MAX);
   assign wr2  = (op2 >= 4'd1) && (op2 <= WR_MAX);
   assign br1  = (op1 == BR_OP_A) || (op1 == BR_OP_B);
   assign br2  = (op2 == BR_OP_A) || (op2 == BR_OP_B);

   assign hazard = wr1 && (rd1 != 4'd0) &&
                   ((rd1 == rs1_2) || (rd1 == rs2_2) || (wr2 && (rd1 == rd2)));
   assign split  = hazard || br1 || br2;

   assign busy        = (state_q != RUN);
   assign fetch_stall = !exec_ready || (state_q == HOLD) || (state_q == FLUSH);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         hold_q       <= '0;
         cnt_q        <= '0;
         issue1_valid <= 1'b0;
         issue1_instr <= '0;
         issue2_valid <= 1'b0;
         issue2_instr <= '0;
         fetch_single <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cnt_q        <= cnt_d;
         issue1_valid <= v1_d;
         issue1_instr <= i1_d;
         issue2_valid <= v2_d;
         issue2_instr <= i2_d;
         fetch_single <= single_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      v1_d     = 1'b0;
      i1_d     = '0;
      v2_d     = 1'b0;
      i2_d     = '0;
      single_d = fetch_single;

      if (branch_taken) begin
         // Overrides any split decided this cycle, so nothing is held.
         state_d = FLUSH;
         cnt_d   = FLUSH_LOAD;
         hold_d  = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (fetch_valid && exec_ready) begin
                  single_d = split;
                  if (split) begin
                     v1_d    = 1'b1;
                     i1_d    = fetch_instr1;
                     hold_d  = fetch_instr2;
                     state_d = HOLD;
                  end else if (!nop1) begin
                     v1_d = 1'b1;
                     i1_d = fetch_instr1;
                     v2_d = !nop2;
                     i2_d = nop2 ? '0 : fetch_instr2;
                  end else if (!nop2) begin
                     // NOP in the older slot: the younger one moves up.
                     v1_d = 1'b1;
                     i1_d = fetch_instr2;
                  end
               end
            end
            HOLD: begin
               if (exec_ready) begin
                  v1_d    = 1'b1;
                  i1_d    = hold_q;
                  state_d = RUN;
               end
            end
            FLUSH: begin
               if (fetch_valid) begin
                  if (cnt_q <= 2'd1) begin
                     cnt_d   = '0;
                     state_d = RUN;
                  end else begin
                     cnt_d = cnt_q - 2'd1;
                  end
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

`ifdef DUAL_ISSUE_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_dual  <= '0;
         perf_split <= '0;
         perf_flush <= '0;
      end else begin
         if (v1_d && v2_d && (perf_dual != '1))
            perf_dual <= perf_dual + 16'd1;
         if ((state_q == RUN) && (state_d == HOLD) && (perf_split != '1))
            perf_split <= perf_split + 16'd1;
         if (branch_taken && (perf_flush != '1))
            perf_flush <= perf_flush + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;

   localparam int unsigned FLUSH_N = 1;

   logic        clk = 1'b0;
   logic        reset, fetch_valid, exec_ready, branch_taken;
   logic [15:0] fetch_instr1, fetch_instr2;
   logic        issue1_valid, issue2_valid, fetch_stall, fetch_single, busy;
   logic [15:0] issue1_instr, issue2_instr;
`ifdef DUAL_ISSUE_PERF_EN
   logic [15:0] perf_dual, perf_split, perf_flush;
`endif

   always #5 clk = ~clk;

   dual_issue_scheduler #(
      .INSTR_W(16), .WR_OP_MAX(9), .BR_OP_A(4'hC), .BR_OP_B(4'hD),
      .FLUSH_CYCLES(FLUSH_N)
   ) dut (
      .clk(clk), .reset(reset),
      .fetch_instr1(fetch_instr1), .fetch_instr2(fetch_instr2),
      .fetch_valid(fetch_valid), .exec_ready(exec_ready),
      .branch_taken(branch_taken),
      .issue1_valid(issue1_valid), .issue1_instr(issue1_instr),
      .issue2_valid(issue2_valid), .issue2_instr(issue2_instr),
      .fetch_stall(fetch_stall), .fetch_single(fetch_single), .busy(busy)
`ifdef DUAL_ISSUE_PERF_EN
      , .perf_dual(perf_dual), .perf_split(perf_split), .perf_flush(perf_flush)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rules
   function automatic bit is_nop(input logic [15:0] x);
      return x[15:12] == 4'd0;
   endfunction
   function automatic bit writes(input logic [15:0] x);
      return (x[15:12] >= 1) && (x[15:12] <= 9);
   endfunction
   function automatic bit is_branch(input logic [15:0] x);
      return (x[15:12] == 4'hC) || (x[15:12] == 4'hD);
   endfunction
   function automatic bit must_split(input logic [15:0] a, input logic [15:0] b);
      bit hz;
      hz = writes(a) && (a[11:8] != 0) &&
           ((a[11:8] == b[7:4]) || (a[11:8] == b[3:0]) ||
            (writes(b) && (a[11:8] == b[11:8])));
      return hz || is_branch(a) || is_branch(b);
   endfunction

   // Behavioural model: a pending held instruction plus pairs left to discard
   bit          started = 0;
   bit          m_v1, m_v2, m_single, m_have_held;
   logic [15:0] m_i1, m_i2, m_held;
   int          m_flush_left;
   logic [15:0] pack_q[$];
   int          m_dual, m_split, m_fl;

   always @(posedge clk) begin
      if (reset) begin
         started = 1;
         m_v1 = 0; m_v2 = 0; m_i1 = 0; m_i2 = 0; m_single = 0;
         m_have_held = 0; m_held = 0; m_flush_left = 0;
         m_dual = 0; m_split = 0; m_fl = 0;
      end else begin
         m_v1 = 0; m_v2 = 0; m_i1 = 0; m_i2 = 0;
         if (branch_taken) begin
            m_have_held  = 0;
            m_flush_left = FLUSH_N;
            if (m_fl < 65535) m_fl++;
         end else if (m_flush_left > 0) begin
            if (fetch_valid) m_flush_left--;
         end else if (m_have_held) begin
            if (exec_ready) begin
               m_v1 = 1; m_i1 = m_held; m_have_held = 0;
            end
         end else if (fetch_valid && exec_ready) begin
            m_single = must_split(fetch_instr1, fetch_instr2);
            if (m_single) begin
               m_v1 = 1; m_i1 = fetch_instr1;
               m_held = fetch_instr2; m_have_held = 1;
               if (m_split < 65535) m_split++;
            end else begin
               pack_q.delete();
               if (!is_nop(fetch_instr1)) pack_q.push_back(fetch_instr1);
               if (!is_nop(fetch_instr2)) pack_q.push_back(fetch_instr2);
               if (pack_q.size() > 0) begin m_v1 = 1; m_i1 = pack_q[0]; end
               if (pack_q.size() > 1) begin
                  m_v2 = 1; m_i2 = pack_q[1];
                  if (m_dual < 65535) m_dual++;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         chk("issue1_valid", issue1_valid, m_v1);
         if (m_v1) chk("issue1_instr", issue1_instr, m_i1);
         chk("issue2_valid", issue2_valid, m_v2);
         if (m_v2) chk("issue2_instr", issue2_instr, m_i2);
         chk("fetch_single", fetch_single, m_single);
         chk("busy", busy, m_have_held || (m_flush_left > 0));
         chk("fetch_stall", fetch_stall, !exec_ready || m_have_held || (m_flush_left > 0));
`ifdef DUAL_ISSUE_PERF_EN
         chk("perf_dual", perf_dual, m_dual);
         chk("perf_split", perf_split, m_split);
         chk("perf_flush", perf_flush, m_fl);
`endif
      end
   end

   // Called at posedge+1; applies inputs and returns at the next posedge+1
   task automatic drive(input logic r, input logic fv, input logic [15:0] a,
                        input logic [15:0] b, input logic er, input logic br);
      #1;
      reset = r; fetch_valid = fv; fetch_instr1 = a; fetch_instr2 = b;
      exec_ready = er; branch_taken = br;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] x;
      x[15:12] = 4'($urandom_range(0, 15));
      x[11:8]  = 4'($urandom_range(0, 3));
      x[7:4]   = 4'($urandom_range(0, 3));
      x[3:0]   = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) x = '0;
      return x;
   endfunction

   initial begin
      reset = 1; fetch_valid = 0; fetch_instr1 = 0; fetch_instr2 = 0;
      exec_ready = 1; branch_taken = 0;
      @(posedge clk); #1;
      drive(1, 0, 16'h0, 16'h0, 1, 0);
      chk("rst_v1", issue1_valid, 0);
      chk("rst_v2", issue2_valid, 0);
      chk("rst_i1", issue1_instr, 0);
      chk("rst_i2", issue2_instr, 0);
      chk("rst_single", fetch_single, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall", fetch_stall, 0);

      // Independent pair
      drive(0, 1, 16'h1123, 16'h2456, 1, 0);
      chk("ind_v1", issue1_valid, 1); chk("ind_i1", issue1_instr, 16'h1123);
      chk("ind_v2", issue2_valid, 1); chk("ind_i2", issue2_instr, 16'h2456);
      chk("ind_stall", fetch_stall, 0);

      // RAW pair splits over two cycles
      drive(0, 1, 16'h1312, 16'h2435, 1, 0);
      chk("raw_v1", issue1_valid, 1); chk("raw_i1", issue1_instr, 16'h1312);
      chk("raw_v2", issue2_valid, 0); chk("raw_stall", fetch_stall, 1);
      chk("raw_busy", busy, 1); chk("raw_single", fetch_single, 1);
      drive(0, 1, 16'h1312, 16'h2435, 1, 0);
      chk("raw2_v1", issue1_valid, 1); chk("raw2_i1", issue1_instr, 16'h2435);
      chk("raw2_v2", issue2_valid, 0); chk("raw2_busy", busy, 0);

      // Branch in slot 1, then taken branch while holding
      drive(0, 1, 16'hC004, 16'h1123, 1, 0);
      chk("br_i1", issue1_instr, 16'hC004); chk("br_busy", busy, 1);
      drive(0, 1, 16'h0, 16'h0, 1, 1);
      chk("brt_v1", issue1_valid, 0); chk("brt_v2", issue2_valid, 0);
      chk("brt_busy", busy, 1);
      drive(0, 1, 16'h0, 16'h0, 1, 0);
      chk("flush_v1", issue1_valid, 0); chk("flush_done", busy, 0);
      drive(0, 1, 16'h0, 16'h0, 1, 0);
      chk("nop_v1", issue1_valid, 0); chk("nop_v2", issue2_valid, 0);

      // exec_ready low while holding
      drive(0, 1, 16'h1312, 16'h2435, 1, 0);
      chk("hs_busy", busy, 1);
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 16'h1312, 16'h2435, 0, 0);
         chk("hs_v1", issue1_valid, 0); chk("hs_stall", fetch_stall, 1);
      end
      drive(0, 1, 16'h1312, 16'h2435, 1, 0);
      chk("hs_rel_v1", issue1_valid, 1); chk("hs_rel_i1", issue1_instr, 16'h2435);
      drive(0, 1, 16'h0, 16'h0, 1, 0);
      chk("hs_once", issue1_valid, 0);

      // rd1 = 0 never creates a hazard
      drive(0, 1, 16'h1045, 16'h2012, 1, 0);
      chk("rd0_v2", issue2_valid, 1); chk("rd0_i2", issue2_instr, 16'h2012);

      // NOP compaction
      drive(0, 1, 16'h0000, 16'h2456, 1, 0);
      chk("nop1_i1", issue1_instr, 16'h2456); chk("nop1_v2", issue2_valid, 0);
      drive(0, 1, 16'h1123, 16'h0ABC, 1, 0);
      chk("nop2_i1", issue1_instr, 16'h1123); chk("nop2_v2", issue2_valid, 0);

      // Reset while flushing
      drive(0, 1, 16'h1312, 16'h2435, 1, 0);
      drive(0, 1, 16'h0, 16'h0, 1, 1);
      chk("rf_busy", busy, 1);
      drive(1, 0, 16'h0, 16'h0, 1, 0);
      chk("rf_v1", issue1_valid, 0); chk("rf_single", fetch_single, 0);
      chk("rf_busy0", busy, 0);

      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
               rand_instr(), rand_instr(), ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 19) == 0));
      end

`ifdef DUAL_ISSUE_PERF_EN
      drive(1, 0, 16'h0, 16'h0, 1, 0);
      for (int n = 0; n < 70000; n++) drive(0, 1, 16'h1123, 16'h2456, 1, 0);
      chk("perf_sat", perf_dual, 16'hFFFF);
`endif

      drive(0, 0, 16'h0, 16'h0, 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
